// File: rtl/mac_accumulator_if.sv
// Stream bundle for mac_accumulator: product beats in, frame results out.
// ACC_W must match the ACC_W of the mac_accumulator instance it connects to.
interface mac_accumulator_if #(
    parameter int ACC_W = 24
);
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      prod;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] acc_out;
    logic [15:0]      out_count;
    logic             overflow;

    // Upstream/downstream side: supplies beats and consumes results.
    modport master (
        output in_valid, prod, in_last, out_ready,
        input  in_ready, out_valid, acc_out, out_count, overflow
    );

    // Accumulator side.
    modport slave (
        input  in_valid, prod, in_last, out_ready,
        output in_ready, out_valid, acc_out, out_count, overflow
    );
endinterface

// File: rtl/mac_accumulator.sv
// Frame accumulator for unsigned 16-bit products. Sums beats with saturation
// until in_last or MAX_LEN beats, then holds the frame result until the
// downstream handshake. ACCUM accepts beats; HOLD presents the result.
module mac_accumulator #(
    parameter int ACC_W   = 24,
    parameter int MAX_LEN = 256
) (
    input  logic           clk,
    input  logic           rst,
    mac_accumulator_if.slave bus
);
    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic [ACC_W-1:0] SAT_MAX   = '1;
    localparam logic [15:0]      LEN_LIMIT = 16'(MAX_LEN);

    state_t           state;
    state_t           state_next;
    logic [ACC_W-1:0] sum;
    logic [15:0]      count;
    logic             ovf;

    logic             accept;
    logic             handshake;
    logic             close;
    logic [ACC_W:0]   sum_wide;
    logic [ACC_W-1:0] sum_sat;
    logic [15:0]      count_inc;
    logic             ovf_next;

    // State register; reset lands in ACCUM so a fresh frame starts cleanly.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (rst) begin
            state <= ACCUM;
        end else begin
            state <= state_next;
        end
    end

    // Next state and handshake outputs; ready/valid are pure functions of state.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        state_next    = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        accept        = 1'b0;
        handshake     = 1'b0;
        case (state)
            ACCUM: begin
                bus.in_ready = 1'b1;
                accept       = bus.in_valid;
                if (close) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                bus.out_valid = 1'b1;
                handshake     = bus.out_ready;
                if (handshake) begin
                    state_next = ACCUM;
                end
            end
            default: state_next = ACCUM;
        endcase
    end

    // Post-update values of the running frame for the beat on the bus.
    always_comb begin
        sum_wide  = {1'b0, sum} + (ACC_W+1)'(bus.prod);
        sum_sat   = sum_wide[ACC_W] ? SAT_MAX : sum_wide[ACC_W-1:0];
        count_inc = count + 16'd1;
        ovf_next  = ovf | sum_wide[ACC_W];
        // count never exceeds MAX_LEN-1 while accumulating, so count_inc cannot wrap.
        close     = accept && (bus.in_last || (count_inc == LEN_LIMIT));
    end

    // Running frame and reported result; the result registers only change on close or consume.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum           <= '0;
            count         <= '0;
            ovf           <= 1'b0;
            bus.acc_out   <= '0;
            bus.out_count <= '0;
            bus.overflow  <= 1'b0;
        end else if (accept) begin
            sum   <= sum_sat;
            count <= count_inc;
            ovf   <= ovf_next;
            if (close) begin
                bus.acc_out   <= sum_sat;
                bus.out_count <= count_inc;
                bus.overflow  <= ovf_next;
            end
        end else if (handshake) begin
            // Result consumed: the next frame starts from zero.
            sum          <= '0;
            count        <= '0;
            ovf          <= 1'b0;
            bus.overflow <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mac_accumulator.sv
// Self-checking bench for mac_accumulator. Three instances cover the default
// configuration, a 16-bit accumulator (saturation) and MAX_LEN=4 (length close).
// A frame-level model predicts ready/valid and every reported result.
module tb_mac_accumulator;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    mac_accumulator_if #(.ACC_W(24)) bus_a ();
    mac_accumulator_if #(.ACC_W(16)) bus_b ();
    mac_accumulator_if #(.ACC_W(24)) bus_c ();

    mac_accumulator #(.ACC_W(24), .MAX_LEN(256)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    mac_accumulator #(.ACC_W(16), .MAX_LEN(256)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));
    mac_accumulator #(.ACC_W(24), .MAX_LEN(4))   dut_c (.clk(clk), .rst(rst), .bus(bus_c));

    // Frame-level model of the selected instance.
    bit          m_hold;
    longint      m_sum;
    int          m_cnt;
    bit          m_ovf;
    longint      r_acc;
    int          r_cnt;
    bit          r_ovf;
    logic [31:0] got_acc;
    logic [15:0] got_cnt;
    logic        got_ovf;

    function automatic int acc_w_of(input int which);
        return (which == 1) ? 16 : 24;
    endfunction

    function automatic int max_len_of(input int which);
        return (which == 2) ? 4 : 256;
    endfunction

    task automatic model_accept(input int which, input logic [15:0] p, input bit l);
        longint lim;
        lim   = (64'sd1 <<< acc_w_of(which)) - 1;
        m_sum = m_sum + longint'(p);
        if (m_sum > lim) begin
            m_sum = lim;
            m_ovf = 1'b1;
        end
        m_cnt++;
        if (l || m_cnt == max_len_of(which)) begin
            m_hold = 1'b1;
            r_acc  = m_sum;
            r_cnt  = m_cnt;
            r_ovf  = m_ovf;
            m_sum  = 0;
            m_cnt  = 0;
            m_ovf  = 1'b0;
        end
    endtask

    task automatic drive_bus(input int which, input bit v, input logic [15:0] p,
                             input bit l, input bit r);
        bus_a.in_valid  = (which == 0) && v;
        bus_a.prod      = (which == 0) ? p : 16'd0;
        bus_a.in_last   = (which == 0) && l;
        bus_a.out_ready = (which == 0) && r;
        bus_b.in_valid  = (which == 1) && v;
        bus_b.prod      = (which == 1) ? p : 16'd0;
        bus_b.in_last   = (which == 1) && l;
        bus_b.out_ready = (which == 1) && r;
        bus_c.in_valid  = (which == 2) && v;
        bus_c.prod      = (which == 2) ? p : 16'd0;
        bus_c.in_last   = (which == 2) && l;
        bus_c.out_ready = (which == 2) && r;
    endtask

    task automatic sample_bus(input int which, output logic rdy, output logic vld,
                              output logic [31:0] acc, output logic [15:0] cnt,
                              output logic ovf);
        case (which)
            0: begin
                rdy = bus_a.in_ready; vld = bus_a.out_valid; acc = 32'(bus_a.acc_out);
                cnt = bus_a.out_count; ovf = bus_a.overflow;
            end
            1: begin
                rdy = bus_b.in_ready; vld = bus_b.out_valid; acc = 32'(bus_b.acc_out);
                cnt = bus_b.out_count; ovf = bus_b.overflow;
            end
            default: begin
                rdy = bus_c.in_ready; vld = bus_c.out_valid; acc = 32'(bus_c.acc_out);
                cnt = bus_c.out_count; ovf = bus_c.overflow;
            end
        endcase
    endtask

    // One clock: sample at the falling edge, compare with the model, drive the
    // next inputs and advance the model to what the coming rising edge does.
    task automatic step(input int which, input bit v, input logic [15:0] p,
                        input bit l, input bit r, output bit took);
        logic        rdy, vld, ovf;
        logic [31:0] acc;
        logic [15:0] cnt;
        @(negedge clk);
        sample_bus(which, rdy, vld, acc, cnt, ovf);
        checks++;
        if (rdy !== !m_hold) begin
            errors++;
            $display("FAIL in_ready bus%0d t=%0t got=%b exp=%b", which, $time, rdy, !m_hold);
        end
        checks++;
        if (vld !== m_hold) begin
            errors++;
            $display("FAIL out_valid bus%0d t=%0t got=%b exp=%b", which, $time, vld, m_hold);
        end
        if (m_hold) begin
            checks++;
            if (acc !== 32'(r_acc) || cnt !== 16'(r_cnt) || ovf !== r_ovf) begin
                errors++;
                $display("FAIL held_result bus%0d t=%0t got acc=%0d cnt=%0d ovf=%b exp acc=%0d cnt=%0d ovf=%b",
                         which, $time, acc, cnt, ovf, r_acc, r_cnt, r_ovf);
            end
        end
        drive_bus(which, v, p, l, r);
        took = 1'b0;
        if (m_hold) begin
            if (r) begin
                m_hold  = 1'b0;
                got_acc = acc;
                got_cnt = cnt;
                got_ovf = ovf;
            end
        end else if (v) begin
            took = 1'b1;
            model_accept(which, p, l);
        end
    endtask

    // Hold a beat on the bus (consuming any pending result) until it is taken.
    task automatic send_beat(input int which, input logic [15:0] p, input bit l);
        bit took;
        for (int i = 0; i < 20; i++) begin
            step(which, 1'b1, p, l, 1'b1, took);
            if (took) return;
        end
        checks++;
        errors++;
        $display("FAIL send_timeout bus%0d got=not_accepted exp=accepted", which);
    endtask

    task automatic drain(input int which);
        bit took;
        step(which, 1'b0, 16'd0, 1'b0, 1'b1, took);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst = 1'b1;
        drive_bus(0, 1'b0, 16'd0, 1'b0, 1'b0);
        repeat (cycles) @(negedge clk);
        rst     = 1'b0;
        m_hold  = 1'b0;
        m_sum   = 0;
        m_cnt   = 0;
        m_ovf   = 1'b0;
        got_acc = 'x;
        got_cnt = 'x;
        got_ovf = 1'bx;
    endtask

    task automatic test_reset();
        logic        rdy, vld, ovf;
        logic [31:0] acc;
        logic [15:0] cnt;
        do_reset(3);
        @(negedge clk);
        for (int w = 0; w < 3; w++) begin
            sample_bus(w, rdy, vld, acc, cnt, ovf);
            checks++;
            if (vld !== 1'b0 || rdy !== 1'b1 || acc !== 32'd0 || cnt !== 16'd0 || ovf !== 1'b0) begin
                errors++;
                $display("FAIL reset_state bus%0d got vld=%b rdy=%b acc=%0d cnt=%0d ovf=%b exp 0 1 0 0 0",
                         w, vld, rdy, acc, cnt, ovf);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit took;
        do_reset(1);
        step(0, 1'b1, 16'd100, 1'b0, 1'b1, took);
        step(0, 1'b1, 16'd200, 1'b0, 1'b1, took);
        step(0, 1'b1, 16'd300, 1'b1, 1'b1, took);
        step(0, 1'b0, 16'd0, 1'b0, 1'b1, took);
        checks++;
        if (got_acc !== 32'd600 || got_cnt !== 16'd3 || got_ovf !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back got acc=%0d cnt=%0d ovf=%b exp acc=600 cnt=3 ovf=0",
                     got_acc, got_cnt, got_ovf);
        end
        step(0, 1'b0, 16'd0, 1'b0, 1'b1, took);
    endtask

    task automatic test_backpressure();
        bit took;
        do_reset(1);
        step(0, 1'b1, 16'd400, 1'b0, 1'b0, took);
        step(0, 1'b1, 16'd600, 1'b1, 1'b0, took);
        repeat (5) step(0, 1'b1, 16'd77, 1'b1, 1'b0, took);
        step(0, 1'b0, 16'd0, 1'b0, 1'b1, took);
        checks++;
        if (got_acc !== 32'd1000 || got_cnt !== 16'd2 || got_ovf !== 1'b0) begin
            errors++;
            $display("FAIL backpressure got acc=%0d cnt=%0d ovf=%b exp acc=1000 cnt=2 ovf=0",
                     got_acc, got_cnt, got_ovf);
        end
        send_beat(0, 16'd5, 1'b1);
        drain(0);
        checks++;
        if (got_acc !== 32'd5 || got_cnt !== 16'd1) begin
            errors++;
            $display("FAIL single_beat got acc=%0d cnt=%0d exp acc=5 cnt=1", got_acc, got_cnt);
        end
    endtask

    task automatic test_saturation();
        do_reset(1);
        send_beat(1, 16'd65535, 1'b0);
        send_beat(1, 16'd1, 1'b1);
        drain(1);
        checks++;
        if (got_acc !== 32'd65535 || got_cnt !== 16'd2 || got_ovf !== 1'b1) begin
            errors++;
            $display("FAIL saturate got acc=%0d cnt=%0d ovf=%b exp acc=65535 cnt=2 ovf=1",
                     got_acc, got_cnt, got_ovf);
        end
        send_beat(1, 16'd5, 1'b1);
        drain(1);
        checks++;
        if (got_acc !== 32'd5 || got_cnt !== 16'd1 || got_ovf !== 1'b0) begin
            errors++;
            $display("FAIL after_saturate got acc=%0d cnt=%0d ovf=%b exp acc=5 cnt=1 ovf=0",
                     got_acc, got_cnt, got_ovf);
        end
    endtask

    task automatic test_max_len();
        do_reset(1);
        for (int i = 0; i < 5; i++) send_beat(2, 16'd10, 1'b0);
        checks++;
        if (got_acc !== 32'd40 || got_cnt !== 16'd4 || got_ovf !== 1'b0) begin
            errors++;
            $display("FAIL max_len_close got acc=%0d cnt=%0d ovf=%b exp acc=40 cnt=4 ovf=0",
                     got_acc, got_cnt, got_ovf);
        end
        send_beat(2, 16'd10, 1'b0);
        send_beat(2, 16'd10, 1'b1);
        drain(2);
        checks++;
        if (got_acc !== 32'd30 || got_cnt !== 16'd3) begin
            errors++;
            $display("FAIL max_len_next got acc=%0d cnt=%0d exp acc=30 cnt=3", got_acc, got_cnt);
        end
        for (int i = 0; i < 4; i++) send_beat(2, 16'd0, 1'b0);
        drain(2);
        checks++;
        if (got_acc !== 32'd0 || got_cnt !== 16'd4) begin
            errors++;
            $display("FAIL zero_beats got acc=%0d cnt=%0d exp acc=0 cnt=4", got_acc, got_cnt);
        end
    endtask

    task automatic test_reset_mid_frame();
        do_reset(1);
        send_beat(0, 16'd7, 1'b0);
        send_beat(0, 16'd9, 1'b0);
        do_reset(1);
        send_beat(0, 16'd4, 1'b1);
        drain(0);
        checks++;
        if (got_acc !== 32'd4 || got_cnt !== 16'd1) begin
            errors++;
            $display("FAIL reset_mid_frame got acc=%0d cnt=%0d exp acc=4 cnt=1", got_acc, got_cnt);
        end
        // Reset while a result is pending must clear it without waiting for a clock.
        send_beat(0, 16'd3, 1'b1);
        @(negedge clk);
        drive_bus(0, 1'b0, 16'd0, 1'b0, 1'b0);
        checks++;
        if (bus_a.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL hold_before_reset got=%b exp=1", bus_a.out_valid);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus_a.out_valid !== 1'b0 || bus_a.in_ready !== 1'b1 || bus_a.acc_out !== 24'd0) begin
            errors++;
            $display("FAIL async_reset got vld=%b rdy=%b acc=%0d exp vld=0 rdy=1 acc=0",
                     bus_a.out_valid, bus_a.in_ready, bus_a.acc_out);
        end
        do_reset(1);
    endtask

    task automatic test_random();
        bit          took;
        bit          v, l, r;
        logic [15:0] p;
        for (int w = 0; w < 3; w++) begin
            do_reset(2);
            for (int i = 0; i < 400; i++) begin
                v = ($urandom % 10) < 7;
                l = ($urandom % 8) == 0;
                r = ($urandom % 2) == 1;
                p = (w == 1) ? 16'($urandom_range(65535, 30000)) : 16'($urandom);
                step(w, v, p, l, r, took);
            end
            drain(w);
            drain(w);
        end
    endtask

    initial begin
        rst = 1'b1;
        drive_bus(0, 1'b0, 16'd0, 1'b0, 1'b0);
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_saturation();
        test_max_len();
        test_reset_mid_frame();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mac_accumulator.md
MAC_ACCUMULATOR -- requirements
Module: mac_accumulator

Interface
REQ-001 Parameter ACC_W, default 24: accumulator and result width in bits; legal range 16..32.
REQ-002 Parameter MAX_LEN, default 256: maximum products per frame; legal range 2..65535.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  product beat present.
REQ-006 in_ready  output  1  block accepts a beat this cycle.
REQ-007 prod  input  16  unsigned product from the upstream 8x8 multiplier.
REQ-008 in_last  input  1  beat is the final one of its frame.
REQ-009 out_valid  output  1  frame result present.
REQ-010 out_ready  input  1  downstream accepts the result.
REQ-011 acc_out  output  ACC_W  saturated frame sum.
REQ-012 out_count  output  16  number of beats in the reported frame.
REQ-013 overflow  output  1  sticky flag: frame sum exceeded 2^ACC_W-1.

Function
REQ-014 The block SHALL have two states, ACCUM and HOLD.
REQ-015 In ACCUM, in_ready SHALL be 1 and out_valid 0; in HOLD, in_ready SHALL be 0 and out_valid 1.
REQ-016 A beat SHALL be accepted only on a cycle with in_valid=1 and in_ready=1; prod and in_last are ignored otherwise.
REQ-017 On acceptance, the running sum SHALL become min(sum + zero-extended prod, 2^ACC_W-1), and the beat count SHALL increment by 1.
REQ-018 If the unsaturated addition exceeds 2^ACC_W-1, the frame overflow flag SHALL be set and held until the frame result is consumed.
REQ-019 The frame SHALL close on the accepting edge when in_last=1 or the count reaches MAX_LEN, whichever comes first.
REQ-020 On close, acc_out, out_count and overflow SHALL load the post-update values, the state SHALL move to HOLD, and out_valid SHALL rise in the next cycle (latency 1 cycle from the last beat).
REQ-021 In HOLD, acc_out, out_count and overflow SHALL remain stable until out_valid and out_ready are both 1.
REQ-022 On the output handshake, the state SHALL return to ACCUM with the running sum, count and overflow cleared, so a new beat can be accepted in the following cycle.
REQ-023 A beat with in_last=1 that is the first beat of a frame SHALL produce a one-beat result (out_count=1).
REQ-024 prod=0 beats SHALL still count toward out_count and MAX_LEN.
REQ-025 out_ready while in ACCUM SHALL have no effect.
REQ-026 All arithmetic SHALL be unsigned; out_count SHALL never exceed MAX_LEN.

Reset
REQ-027 While rst=1, the state SHALL be ACCUM, and running sum, count, acc_out, out_count and overflow SHALL be 0; out_valid SHALL be 0 and in_ready 1 from the next clock after rst deasserts.
REQ-028 A reset asserted mid-frame or in HOLD SHALL discard all partial and pending results; the first frame after reset SHALL contain only beats accepted after reset.
REQ-029 Reset assertion SHALL take effect without a clock edge; deassertion is synchronized externally.

Verification
REQ-030 Assert rst for 3 cycles, then release -> out_valid=0, in_ready=1, acc_out=0, out_count=0, overflow=0.
REQ-031 Send beats 100, 200 and 300 back to back, with in_last on the third, and out_ready=1 -> out_valid high one cycle after the third beat, acc_out=600, out_count=3, overflow=0; in_ready high again the next cycle.
REQ-032 Close a frame with sum 1000 and hold out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0 throughout, acc_out stays 1000, and no beat is accepted; raise out_ready -> one handshake, then return to ACCUM.
REQ-033 With ACC_W=16, send 65535 then 1 (in_last) -> acc_out=65535, out_count=2, overflow=1; the next frame of single beat 5 -> acc_out=5, overflow=0.
REQ-034 With MAX_LEN=4, send 6 beats of 10 with in_last always 0 -> first result acc_out=40, out_count=4; beats 5 and 6 start the next frame.
REQ-035 Accept beats 7 and 9, assert rst for 1 cycle, then send beat 4 with in_last -> acc_out=4, out_count=1.
